// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues word requests to imem, queues returned instructions with their PCs for decode.
// Latency: imem_rvalid in cycle N shows up as id_valid in cycle N+1 (registered queue, no bypass).
// Backpressure: pc_stall holds the PC while the queue plus in-flight requests fill DEPTH; id_ready low holds the head entry.
module if_fetch_unit #(
    parameter int          DEPTH     = 2,             // power of two, >= 2
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    output logic        pc_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_fault
);

    localparam int PW = $clog2(DEPTH);   // queue / tag pointer width
    localparam int CW = PW + 1;          // counters hold 0..DEPTH
    localparam int SW = CW + 2;          // headroom for the occupancy sum

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [CW-1:0] r_count;              // decode queue occupancy
    logic [CW-1:0] r_outstanding;        // granted, live, unreturned requests
    logic [CW-1:0] r_discard;            // granted requests whose responses get dropped

    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic          r_q_fault [DEPTH];
    logic [PW-1:0] r_q_wptr;
    logic [PW-1:0] r_q_rptr;

    logic [31:0]   r_tag     [DEPTH];    // PC recorded at each grant, popped per live response
    logic [PW-1:0] r_tag_wptr;
    logic [PW-1:0] r_tag_rptr;

    // ---------------------------------------------------------------
    // Combinational control
    // ---------------------------------------------------------------
    logic          w_pop;
    logic          w_aligned;
    logic [SW-1:0] w_sum;
    logic          w_space;
    logic          w_fetch_ok;
    logic          w_accept;
    logic          w_mis_enq;
    logic          w_rsp_drop;
    logic          w_rsp_take;
    logic          w_rsp_consumed;
    logic          w_q_push;
    logic [31:0]   w_push_instr;
    logic [31:0]   w_push_pc;
    logic          w_push_fault;

    assign w_pop      = (r_count != '0) & id_ready;
    assign w_aligned  = (pc_in[1:0] == 2'b00);

    // Every queue slot is reserved from grant until the entry leaves, and
    // discarded requests still occupy a slot until their response returns.
    // The pop credit is safe because the pop is committed on the same edge.
    assign w_sum      = SW'(r_count) + SW'(r_outstanding) + SW'(r_discard) - SW'(w_pop);
    assign w_space    = (w_sum < SW'(DEPTH));

    // Reset gates the request so nothing leaves the block while RST is held.
    assign w_fetch_ok = !RST & !redirect & w_space;

    // Once raised, the request cannot fall before grant: pc_in is held by
    // pc_stall and the occupancy sum can only shrink while waiting.
    assign imem_req   = w_fetch_ok & w_aligned;
    assign imem_addr  = pc_in;
    assign w_accept   = imem_req & imem_gnt;

    // A misaligned PC is resolved locally as a fault entry. It waits for all
    // live requests to return so the fault stays in program order behind them.
    assign w_mis_enq  = w_fetch_ok & !w_aligned & (r_outstanding == '0);

    assign pc_stall   = RST | !(w_accept | w_mis_enq | redirect);

    // Responses with neither a live nor a discard request behind them are ignored.
    assign w_rsp_drop     = imem_rvalid & (r_discard != '0);
    assign w_rsp_take     = imem_rvalid & (r_discard == '0) & (r_outstanding != '0);
    assign w_rsp_consumed = w_rsp_drop | w_rsp_take;

    assign w_q_push     = !redirect & (w_rsp_take | w_mis_enq);
    assign w_push_instr = (w_mis_enq | imem_err) ? NOP_INSTR : imem_rdata;
    assign w_push_pc    = w_mis_enq ? pc_in : r_tag[r_tag_rptr];
    assign w_push_fault = w_mis_enq | imem_err;

    assign id_valid = (r_count != '0);
    assign id_instr = r_q_instr[r_q_rptr];
    assign id_pc    = r_q_pc[r_q_rptr];
    assign id_fault = r_q_fault[r_q_rptr];

    // ---------------------------------------------------------------
    // Sequential logic
    // ---------------------------------------------------------------

    // Occupancy, in-flight and discard counters; redirect moves all live requests to discard.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            r_count       <= '0;
            r_outstanding <= '0;
            // A response landing this cycle retires one request of either kind.
            r_discard     <= r_discard + r_outstanding - CW'(w_rsp_consumed);
        end else begin
            r_count       <= r_count + CW'(w_q_push) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_take);
            r_discard     <= r_discard - CW'(w_rsp_drop);
        end
    end

    // Queue and tag FIFO pointers; redirect empties both.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
        end else if (redirect) begin
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_tag_wptr <= '0;
            r_tag_rptr <= '0;
        end else begin
            if (w_q_push)   r_q_wptr   <= r_q_wptr + 1'b1;
            if (w_pop)      r_q_rptr   <= r_q_rptr + 1'b1;
            if (w_accept)   r_tag_wptr <= r_tag_wptr + 1'b1;
            if (w_rsp_take) r_tag_rptr <= r_tag_rptr + 1'b1;
        end
    end

    // Queue payload storage; validity is tracked by the counters, so no reset needed.
    always_ff @(posedge CLK) begin
        if (w_q_push) begin
            r_q_instr[r_q_wptr] <= w_push_instr;
            r_q_pc[r_q_wptr]    <= w_push_pc;
            r_q_fault[r_q_wptr] <= w_push_fault;
        end
    end

    // Tag storage: capture the fetch PC at grant.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_tag[r_tag_wptr] <= pc_in;
        end
    end

    // ---------------------------------------------------------------
    // Protocol checks
    // ---------------------------------------------------------------

    // Memory must not return a response nobody asked for.
    a_no_orphan_rsp: assert property (@(posedge CLK) disable iff (RST)
        imem_rvalid |-> (r_outstanding != '0 || r_discard != '0));

    // A pending request keeps its address until granted, unless redirected.
    a_req_stable: assert property (@(posedge CLK) disable iff (RST)
        (imem_req && !imem_gnt && !redirect) |=>
            (redirect || (imem_req && imem_addr == $past(imem_addr))));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] pc_in;
    logic        redirect;
    logic        pc_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;

    if_fetch_unit #(.DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pc_in      (pc_in),
        .redirect   (redirect),
        .pc_stall   (pc_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_fault   (id_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;
    int cycle;

    // Values sampled at the falling edge of the cycle just completed.
    logic        s_req, s_stall, s_valid, s_fault, s_acc, s_redirect;
    logic [31:0] s_addr, s_instr, s_pc;

    // Memory / PC-stage environment knobs.
    logic        mem_hold;
    logic [31:0] err_addr;
    logic [31:0] redir_target;
    logic [31:0] pend[$];

    // Entries accepted by decode.
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic        got_fault[$];
    int          got_cyc[$];

    // One clock cycle: sample at negedge, then model PC stage and memory after the edge.
    task automatic tick();
        logic [31:0] a;
        #4;
        s_req      = imem_req;
        s_addr     = imem_addr;
        s_stall    = pc_stall;
        s_valid    = id_valid;
        s_instr    = id_instr;
        s_pc       = id_pc;
        s_fault    = id_fault;
        s_acc      = imem_req & imem_gnt;
        s_redirect = redirect;
        if (id_valid && id_ready) begin
            got_pc.push_back(id_pc);
            got_instr.push_back(id_instr);
            got_fault.push_back(id_fault);
            got_cyc.push_back(cycle);
        end
        @(posedge CLK);
        #1;
        if (!s_stall) pc_in = s_redirect ? redir_target : pc_in + 32'd4;
        redirect = 1'b0;
        if (s_acc) pend.push_back(s_addr);
        if (pend.size() != 0 && !mem_hold) begin
            a           = pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = a | 32'hA000_0000;
            imem_err    = (a == err_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            imem_err    = 1'b0;
        end
        cycle++;
    endtask

    // Reset DUT and environment; returns one time unit after a rising edge.
    task automatic do_reset(input logic [31:0] start_pc);
        RST         = 1'b1;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_err    = 1'b0;
        imem_gnt    = 1'b1;
        id_ready    = 1'b1;
        mem_hold    = 1'b0;
        err_addr    = 32'hFFFF_FFFF;
        pend.delete();
        got_pc.delete();
        got_instr.delete();
        got_fault.delete();
        got_cyc.delete();
        @(posedge CLK);
        #1;
        pc_in = start_pc;
        RST   = 1'b0;
        cycle = 0;
    endtask

    task automatic test_reset();
        RST          = 1'b1;
        pc_in        = 32'h0;
        redirect     = 1'b0;
        imem_gnt     = 1'b1;
        imem_rvalid  = 1'b1;
        imem_rdata   = 32'h1234_5678;
        imem_err     = 1'b0;
        id_ready     = 1'b1;
        mem_hold     = 1'b0;
        err_addr     = 32'hFFFF_FFFF;
        redir_target = 32'h0;
        cycle        = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid c%0d: got %b want 0", c, id_valid); end
            n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req c%0d: got %b want 0", c, imem_req); end
            n_vec++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL reset_stall c%0d: got %b want 1", c, pc_stall); end
        end
        @(posedge CLK);
        #1;
        imem_rvalid = 1'b0;
        RST = 1'b0;
        pend.delete();
        tick();
        n_vec++; if (s_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", s_req); end
        n_vec++; if (s_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h want 00000000", s_addr); end
        tick();
        // Reset in mid-flight: everything cleared, memory side also reset.
        RST = 1'b1;
        #4;
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_req: got %b want 0", imem_req); end
        n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", id_valid); end
        n_vec++; if (pc_stall !== 1'b1) begin n_err++; $display("FAIL midrst_stall: got %b want 1", pc_stall); end
        @(posedge CLK);
        #1;
        pend.delete();
        got_pc.delete(); got_instr.delete(); got_fault.delete(); got_cyc.delete();
        imem_rvalid = 1'b0;
        pc_in = 32'h40;
        RST = 1'b0;
        cycle = 0;
        tick();
        n_vec++; if (s_addr !== 32'h40 || s_req !== 1'b1) begin n_err++; $display("FAIL midrst_restart: got req=%b addr=%h want req=1 addr=00000040", s_req, s_addr); end
        tick();
        tick();
        n_vec++; if (got_pc.size() != 1) begin n_err++; $display("FAIL midrst_count: got %0d entries want 1", got_pc.size()); end
        else begin
            n_vec++; if (got_pc[0] !== 32'h40) begin n_err++; $display("FAIL midrst_pc: got %h want 00000040", got_pc[0]); end
        end
    endtask

    task automatic test_streaming();
        do_reset(32'h0);
        for (int c = 0; c < 10; c++) tick();
        n_vec++; if (got_pc.size() != 8) begin n_err++; $display("FAIL stream_count: got %0d want 8", got_pc.size()); end
        for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
            n_vec++; if (got_pc[i] !== 32'(4 * i)) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got_pc[i], 32'(4 * i)); end
            n_vec++; if (got_instr[i] !== (32'(4 * i) | 32'hA000_0000)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, got_instr[i], 32'(4 * i) | 32'hA000_0000); end
            n_vec++; if (got_fault[i] !== 1'b0) begin n_err++; $display("FAIL stream_fault[%0d]: got %b want 0", i, got_fault[i]); end
            n_vec++; if (got_cyc[i] != i + 2) begin n_err++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, got_cyc[i], i + 2); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        do_reset(32'h0);
        for (int c = 0; c < 12; c++) begin
            id_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            tick();
            if (c >= 3 && c <= 7) begin
                n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL bp_req c%0d: got %b want 0", c, s_req); end
                n_vec++; if (s_stall !== 1'b1) begin n_err++; $display("FAIL bp_stall c%0d: got %b want 1", c, s_stall); end
                n_vec++; if (s_pc !== 32'h4 || s_instr !== 32'hA000_0004) begin n_err++; $display("FAIL bp_head c%0d: got pc=%h instr=%h want pc=00000004 instr=a0000004", c, s_pc, s_instr); end
            end
        end
        n_vec++; if (got_pc.size() != 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got_pc.size()); end
        for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
            n_vec++; if (got_pc[i] !== exp_pc[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_pc[i], exp_pc[i]); end
        end
    endtask

    task automatic test_slow_grant();
        do_reset(32'h0);
        for (int c = 0; c < 5; c++) begin
            imem_gnt = (c >= 3) ? 1'b1 : 1'b0;
            tick();
            if (c <= 3) begin
                n_vec++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin n_err++; $display("FAIL sg_req c%0d: got req=%b addr=%h want req=1 addr=00000000", c, s_req, s_addr); end
                n_vec++; if (s_stall !== (c < 3)) begin n_err++; $display("FAIL sg_stall c%0d: got %b want %b", c, s_stall, c < 3); end
            end else begin
                n_vec++; if (s_addr !== 32'h4) begin n_err++; $display("FAIL sg_next_addr: got %h want 00000004", s_addr); end
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset(32'h0);
        mem_hold     = 1'b1;
        redir_target = 32'h100;
        for (int c = 0; c < 7; c++) begin
            if (c == 2) begin
                redirect = 1'b1;
                mem_hold = 1'b0;
            end
            tick();
            if (c == 2) begin
                n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rd_req_in_redirect: got %b want 0", s_req); end
                n_vec++; if (s_stall !== 1'b0) begin n_err++; $display("FAIL rd_stall_in_redirect: got %b want 0", s_stall); end
            end
            if (c == 3 || c == 4) begin
                n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rd_stale_drop c%0d: got valid=%b want 0", c, s_valid); end
            end
        end
        n_vec++; if (got_pc.size() != 1) begin n_err++; $display("FAIL rd_count: got %0d want 1", got_pc.size()); end
        else begin
            n_vec++; if (got_pc[0] !== 32'h100 || got_instr[0] !== 32'hA000_0100) begin n_err++; $display("FAIL rd_first_new: got pc=%h instr=%h want pc=00000100 instr=a0000100", got_pc[0], got_instr[0]); end
            n_vec++; if (got_cyc[0] != 6) begin n_err++; $display("FAIL rd_first_cycle: got %0d want 6", got_cyc[0]); end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset(32'h0);
        redir_target = 32'h200;
        for (int c = 0; c < 6; c++) begin
            id_ready = (c <= 2) ? 1'b0 : 1'b1;
            if (c == 2) redirect = 1'b1;
            tick();
            if (c == 3) begin
                n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rf_flush: got valid=%b want 0", s_valid); end
                n_vec++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin n_err++; $display("FAIL rf_resume: got req=%b addr=%h want req=1 addr=00000200", s_req, s_addr); end
            end
        end
        n_vec++; if (got_pc.size() != 1) begin n_err++; $display("FAIL rf_count: got %0d want 1", got_pc.size()); end
        else begin
            n_vec++; if (got_pc[0] !== 32'h200) begin n_err++; $display("FAIL rf_first_pc: got %h want 00000200", got_pc[0]); end
        end
    endtask

    task automatic test_faults();
        do_reset(32'h0);
        err_addr = 32'h8;
        for (int c = 0; c < 6; c++) tick();
        n_vec++; if (got_pc.size() != 4) begin n_err++; $display("FAIL ferr_count: got %0d want 4", got_pc.size()); end
        else begin
            n_vec++; if (got_pc[2] !== 32'h8) begin n_err++; $display("FAIL ferr_pc: got %h want 00000008", got_pc[2]); end
            n_vec++; if (got_fault[2] !== 1'b1) begin n_err++; $display("FAIL ferr_fault: got %b want 1", got_fault[2]); end
            n_vec++; if (got_instr[2] !== 32'h0000_0013) begin n_err++; $display("FAIL ferr_instr: got %h want 00000013", got_instr[2]); end
            n_vec++; if (got_fault[3] !== 1'b0 || got_instr[3] !== 32'hA000_000C) begin n_err++; $display("FAIL ferr_after: got fault=%b instr=%h want fault=0 instr=a000000c", got_fault[3], got_instr[3]); end
        end
        // Misaligned PC resolves locally with no memory request.
        do_reset(32'h6);
        tick();
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL mis_req: got %b want 0", s_req); end
        n_vec++; if (s_stall !== 1'b0) begin n_err++; $display("FAIL mis_stall: got %b want 0", s_stall); end
        tick();
        n_vec++; if (s_valid !== 1'b1 || s_pc !== 32'h6) begin n_err++; $display("FAIL mis_entry: got valid=%b pc=%h want valid=1 pc=00000006", s_valid, s_pc); end
        n_vec++; if (s_fault !== 1'b1 || s_instr !== 32'h0000_0013) begin n_err++; $display("FAIL mis_fault: got fault=%b instr=%h want fault=1 instr=00000013", s_fault, s_instr); end
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL mis_req2: got %b want 0", s_req); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_slow_grant();
        test_redirect_outstanding();
        test_redirect_flush();
        test_faults();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
